// File: rtl/cpu_debug_probe.sv
// Run-control and register-readout probe between the CPU core and the board.
// Provides halt/step/resume, a data breakpoint, a halt snapshot and a saturating run-cycle count.
module cpu_debug_probe #(
  parameter int W    = 8,
  parameter int NREG = 16,
  parameter int AW   = 8,
  parameter int CW   = 16
) (
  input  logic                clock,
  input  logic                reset_N,
  input  logic [NREG*W-1:0]   obs_bus,
  input  logic [AW-1:0]       resad,
  output logic [W-1:0]        resdt,
  input  logic                halt_cmd,
  input  logic                step_cmd,
  input  logic                resume_cmd,
  input  logic                bp_en,
  input  logic [AW-1:0]       bp_sel,
  input  logic [W-1:0]        bp_val,
  output logic                cpu_en,
  output logic                halted,
  output logic                bp_hit,
  output logic [CW-1:0]       run_cycles
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam logic [AW:0] NREG_V = (AW+1)'(NREG);

  state_t              state_r;
  state_t              state_next_s;
  logic                bp_mask_r;
  logic                mask_next_s;
  logic                bp_hit_r;
  logic                bp_set_s;
  logic                bp_clr_s;
  logic                bp_match_s;
  logic [NREG*W-1:0]   snap_r;
  logic [W-1:0]        resdt_r;
  logic [W-1:0]        resdt_next_s;
  logic [CW-1:0]       run_cycles_r;

  function automatic logic idx_ok(input logic [AW-1:0] idx);
    return ({1'b0, idx} < NREG_V);
  endfunction

  // Out-of-range indices yield zero, which is also the readout value for them.
  function automatic logic [W-1:0] word_at(input logic [NREG*W-1:0] bus, input logic [AW-1:0] idx);
    logic [W-1:0] w;
    w = {W{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      w = ({1'b0, idx} == (AW+1)'(i)) ? bus[i*W +: W] : w;
    end
    return w;
  endfunction

  // Breakpoint compare, suppressed in the first run cycle after a resume
  always_comb begin
    bp_match_s = 1'b0;
    if (bp_en && !bp_mask_r && idx_ok(bp_sel)) begin
      bp_match_s = (word_at(obs_bus, bp_sel) == bp_val);
    end else begin
      bp_match_s = 1'b0;
    end
  end

  // Next-state and flag control for run / halt / single-step
  always_comb begin
    state_next_s = state_r;
    mask_next_s  = 1'b0;
    bp_set_s     = 1'b0;
    bp_clr_s     = 1'b0;
    case (state_r)
      ST_RUN: begin
        bp_set_s = bp_match_s;
        if (halt_cmd || bp_match_s) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_HALT: begin
        if (resume_cmd) begin
          state_next_s = ST_RUN;
          bp_clr_s     = 1'b1;
          mask_next_s  = 1'b1;
        end else if (step_cmd) begin
          state_next_s = ST_STEP;
        end else begin
          state_next_s = ST_HALT;
        end
      end
      ST_STEP: state_next_s = ST_HALT;
      default: state_next_s = ST_RUN;
    endcase
  end

  // Readout source: frozen snapshot while halted, live bus otherwise
  always_comb begin
    resdt_next_s = {W{1'b0}};
    if (state_r == ST_HALT) begin
      resdt_next_s = word_at(snap_r, resad);
    end else begin
      resdt_next_s = word_at(obs_bus, resad);
    end
  end

  // State, one-cycle breakpoint mask and sticky hit flag
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_r   <= ST_RUN;
      bp_mask_r <= 1'b0;
      bp_hit_r  <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      bp_mask_r <= mask_next_s;
      if (bp_clr_s) begin
        bp_hit_r <= 1'b0;
      end else if (bp_set_s) begin
        bp_hit_r <= 1'b1;
      end
    end
  end

  // Snapshot capture on every entry into HALT
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      snap_r <= {(NREG*W){1'b0}};
    end else if ((state_next_s == ST_HALT) && (state_r != ST_HALT)) begin
      snap_r <= obs_bus;
    end
  end

  // Registered readout data
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      resdt_r <= {W{1'b0}};
    end else begin
      resdt_r <= resdt_next_s;
    end
  end

  // Saturating count of enabled CPU cycles
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      run_cycles_r <= {CW{1'b0}};
    end else if ((state_r != ST_HALT) && (run_cycles_r != {CW{1'b1}})) begin
      run_cycles_r <= run_cycles_r + CW'(1);
    end
  end

  assign cpu_en     = (state_r != ST_HALT);
  assign halted     = (state_r == ST_HALT);
  assign bp_hit     = bp_hit_r;
  assign resdt      = resdt_r;
  assign run_cycles = run_cycles_r;

endmodule

// File: tb/tb_cpu_debug_probe.sv
// Self-checking bench for cpu_debug_probe: directed run-control scenarios plus a
// randomized phase, checked against a behavioural model of the run-control rules.
module tb_cpu_debug_probe;
  localparam int W = 8;
  localparam int NREG = 16;
  localparam int AW = 8;

  logic              clock = 1'b0;
  logic              reset_N;
  logic [NREG*W-1:0] obs_bus;
  logic [AW-1:0]     resad;
  logic              halt_cmd, step_cmd, resume_cmd, bp_en;
  logic [AW-1:0]     bp_sel;
  logic [W-1:0]      bp_val;
  logic [W-1:0]      resdt, sat_resdt;
  logic              cpu_en, halted, bp_hit;
  logic              sat_cpu_en, sat_halted, sat_bp_hit;
  logic [15:0]       run_cycles;
  logic [3:0]        sat_run_cycles;

  cpu_debug_probe #(.W(W), .NREG(NREG), .AW(AW), .CW(16)) dut (
    .clock(clock), .reset_N(reset_N), .obs_bus(obs_bus), .resad(resad), .resdt(resdt),
    .halt_cmd(halt_cmd), .step_cmd(step_cmd), .resume_cmd(resume_cmd), .bp_en(bp_en),
    .bp_sel(bp_sel), .bp_val(bp_val), .cpu_en(cpu_en), .halted(halted), .bp_hit(bp_hit),
    .run_cycles(run_cycles)
  );

  cpu_debug_probe #(.W(W), .NREG(NREG), .AW(AW), .CW(4)) u_sat (
    .clock(clock), .reset_N(reset_N), .obs_bus(obs_bus), .resad(resad), .resdt(sat_resdt),
    .halt_cmd(halt_cmd), .step_cmd(step_cmd), .resume_cmd(resume_cmd), .bp_en(bp_en),
    .bp_sel(bp_sel), .bp_val(bp_val), .cpu_en(sat_cpu_en), .halted(sat_halted),
    .bp_hit(sat_bp_hit), .run_cycles(sat_run_cycles)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail = 0;

  // model of the probe's observable behaviour
  bit         m_halted, m_stepping, m_mask, m_bp_hit;
  logic [7:0] m_snap [NREG];
  logic [7:0] m_resdt;
  int         m_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_halted = 0; m_stepping = 0; m_mask = 0; m_bp_hit = 0;
    m_resdt = 8'h00; m_count = 0;
    for (int i = 0; i < NREG; i++) m_snap[i] = 8'h00;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".cpu_en"}, 32'(cpu_en), 32'(!m_halted));
    check({tag, ".halted"}, 32'(halted), 32'(m_halted));
    check({tag, ".bp_hit"}, 32'(bp_hit), 32'(m_bp_hit));
    check({tag, ".resdt"}, 32'(resdt), 32'(m_resdt));
    check({tag, ".run16"}, 32'(run_cycles), (m_count > 65535) ? 32'd65535 : 32'(m_count));
    check({tag, ".run4"}, 32'(sat_run_cycles), (m_count > 15) ? 32'd15 : 32'(m_count));
  endtask

  // advance one clock: predict from current inputs, clock, then compare
  task automatic tick(input string tag);
    bit nh, ns, nm, nb, hit, enabled;
    logic [7:0] nres;
    int ra, bi;
    enabled = !m_halted;
    ra = int'(resad);
    if (ra >= NREG) nres = 8'h00;
    else if (m_halted) nres = m_snap[ra];
    else nres = obs_bus[ra*W +: W];
    nh = m_halted; ns = 0; nm = 0; nb = m_bp_hit;
    if (m_stepping) begin
      nh = 1;
    end else if (m_halted) begin
      if (resume_cmd) begin nh = 0; nb = 0; nm = 1; end
      else if (step_cmd) begin nh = 0; ns = 1; end
    end else begin
      hit = 0;
      bi = int'(bp_sel);
      if (bp_en && !m_mask && bi < NREG) begin
        if (obs_bus[bi*W +: W] == bp_val) hit = 1;
      end
      if (hit) nb = 1;
      if (halt_cmd || hit) nh = 1;
    end
    if (nh && !m_halted) begin
      for (int i = 0; i < NREG; i++) m_snap[i] = obs_bus[i*W +: W];
    end
    @(posedge clock);
    #1;
    m_halted = nh; m_stepping = ns; m_mask = nm; m_bp_hit = nb;
    m_resdt = nres;
    m_count += enabled ? 1 : 0;
    check_all(tag);
  endtask

  task automatic set_reg(input int i, input logic [7:0] v);
    obs_bus[i*W +: W] = v;
  endtask

  initial begin
    int cnt;
    reset_N = 1'b0; obs_bus = '0; resad = 8'd8;
    halt_cmd = 0; step_cmd = 0; resume_cmd = 0; bp_en = 0; bp_sel = 8'd0; bp_val = 8'h00;
    set_reg(8, 8'h5A);
    model_reset();
    #3;
    check_all("reset");
    #4 reset_N = 1'b1;

    // readout after reset
    tick("rd0");
    check("rd_5a", 32'(resdt), 32'h5A);
    check("rd_run1", 32'(run_cycles), 32'd1);
    resad = 8'h20;
    tick("rd_oor");
    check("rd_oor_zero", 32'(resdt), 32'h0);
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < NREG; i++) set_reg(i, 8'($urandom));
      resad = 8'($urandom_range(0, 19));
      tick("run_rand");
    end

    // halt and snapshot
    resad = 8'd3; set_reg(3, 8'h11); halt_cmd = 1;
    tick("halt");
    check("halt_cpu_en", 32'(cpu_en), 32'd0);
    check("halt_halted", 32'(halted), 32'd1);
    halt_cmd = 0; set_reg(3, 8'h22);
    tick("halt_hold");
    check("snap_11", 32'(resdt), 32'h11);

    // single step refreshes the snapshot
    set_reg(3, 8'h33); step_cmd = 1;
    tick("step");
    check("step_en", 32'(cpu_en), 32'd1);
    step_cmd = 0;
    tick("step_back");
    check("step_halted", 32'(halted), 32'd1);
    set_reg(3, 8'h44);
    tick("step_rd");
    check("snap_33", 32'(resdt), 32'h33);
    cnt = 0; step_cmd = 1;
    repeat (6) begin
      tick("step_hold");
      if (cpu_en) cnt++;
    end
    step_cmd = 0;
    check("step_hold_cnt", 32'(cnt), 32'd3);

    // breakpoint on reg 2 counting up
    bp_en = 1; bp_sel = 8'd2; bp_val = 8'h07; set_reg(2, 8'h00); resume_cmd = 1;
    tick("resume");
    resume_cmd = 0;
    for (int k = 0; k < 20; k++) begin
      if (halted) break;
      set_reg(2, obs_bus[2*W +: W] + 8'd1);
      tick("bp_count");
    end
    check("bp_halted", 32'(halted), 32'd1);
    check("bp_hit_set", 32'(bp_hit), 32'd1);
    resad = 8'd2; set_reg(2, 8'h09);
    tick("bp_rd");
    check("bp_snap_07", 32'(resdt), 32'h07);
    set_reg(2, 8'h07); resume_cmd = 1;
    tick("bp_resume");
    check("bp_hit_clr", 32'(bp_hit), 32'd0);
    resume_cmd = 0;
    tick("bp_masked");
    check("bp_mask_run", 32'(halted), 32'd0);
    set_reg(2, 8'h08);
    tick("bp_left");

    // priorities
    halt_cmd = 1;
    tick("pri_halt");
    halt_cmd = 0; step_cmd = 1; resume_cmd = 1;
    tick("pri_sr");
    step_cmd = 0; resume_cmd = 0;
    tick("pri_run");
    check("pri_not_step", 32'(halted), 32'd0);
    set_reg(2, 8'h07); halt_cmd = 1;
    tick("pri_hb");
    check("pri_hb_hit", 32'(bp_hit), 32'd1);
    halt_cmd = 0; set_reg(2, 8'h00); resume_cmd = 1;
    tick("pri_resume");
    resume_cmd = 0;

    // randomized run-control traffic
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < NREG; i++) set_reg(i, 8'($urandom));
      if ($urandom_range(0, 3) == 0) set_reg(2, 8'h07);
      halt_cmd = ($urandom_range(0, 9) == 0);
      step_cmd = ($urandom_range(0, 2) == 0);
      resume_cmd = ($urandom_range(0, 5) == 0);
      bp_en = ($urandom_range(0, 1) == 1);
      bp_sel = 8'($urandom_range(0, 17));
      resad = 8'($urandom_range(0, 19));
      tick("rand");
    end
    check("sat_f", 32'(sat_run_cycles), 32'hF);

    // async reset while stepping
    halt_cmd = 1; step_cmd = 0; resume_cmd = 0; bp_en = 0;
    tick("ar_halt");
    halt_cmd = 0;
    tick("ar_idle");
    step_cmd = 1;
    tick("ar_step");
    check("ar_in_step", 32'(cpu_en), 32'd1);
    step_cmd = 0;
    #2 reset_N = 1'b0;
    #1;
    model_reset();
    check("ar_cpu_en", 32'(cpu_en), 32'd1);
    check("ar_halted", 32'(halted), 32'd0);
    check("ar_run0", 32'(run_cycles), 32'd0);
    check("ar_sat0", 32'(sat_run_cycles), 32'd0);
    check("ar_bp_hit", 32'(bp_hit), 32'd0);
    #2 reset_N = 1'b1;
    resad = 8'd5;
    tick("post_rst");
    tick("post_rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
